// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Each cycle the arbiter
// may accept one operation, drives its select/shift/operands to the ALU, and
// registers the ALU result into a single-entry response holding register.
// A new operation can be accepted while a result is held only if the consumer
// takes the held result in the same cycle, giving one operation per cycle.
//
// Arbitration:
//   default                    round-robin; on contention the requester that
//                              was not granted last wins.
//   ALU_ARB_FIXED_PRIO_EN      fixed priority; requester 0 always wins on
//                              contention and no last-grant state exists.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   req_valid      [1:0]  requester i presents an operation
//   req_ready      [1:0]  requester i's operation accepted this cycle
//   req_sel        [2*SEL_SIZE-1:0]    operation select per requester
//   req_shift_amt  [2*SHIFT_SIZE-1:0]  shift amount per requester
//   req_a, req_b   [2*XLEN-1:0]        operands per requester
//   rsp_valid      registered result available
//   rsp_ready      consumer takes the result
//   rsp_data       [XLEN-1:0] registered ALU result
//   rsp_id         requester index owning rsp_data
//   alu_enable     enable to the shared ALU
//   alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b   ALU inputs
//   alu_data_out   [XLEN-1:0] combinational ALU result
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int SEL_SIZE   = 4,
   parameter int SHIFT_SIZE = 5,
   parameter int XLEN       = 32
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [2*SEL_SIZE-1:0]   req_sel,
   input  logic [2*SHIFT_SIZE-1:0] req_shift_amt,
   input  logic [2*XLEN-1:0]       req_a,
   input  logic [2*XLEN-1:0]       req_b,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [XLEN-1:0]         rsp_data,
   output logic                    rsp_id,

   output logic                    alu_enable,
   output logic [SEL_SIZE-1:0]     alu_sel,
   output logic [SHIFT_SIZE-1:0]   alu_shift_amt,
   output logic [XLEN-1:0]         alu_data_in_a,
   output logic [XLEN-1:0]         alu_data_in_b,
   input  logic [XLEN-1:0]         alu_data_out
);

   typedef enum logic {
      ST_IDLE = 1'b0,   // no result held
      ST_HOLD = 1'b1    // result held, rsp_valid asserted
   } state_e;

   state_e                 state_q, state_d;
   logic [XLEN-1:0]        rsp_data_q, rsp_data_d;
   logic                   rsp_id_q, rsp_id_d;

   logic                   can_accept;
   logic                   grant_any;
   logic                   grant_idx;

   // Per-requester views of the packed request buses.
   logic [SEL_SIZE-1:0]    sel_s   [2];
   logic [SHIFT_SIZE-1:0]  shamt_s [2];
   logic [XLEN-1:0]        a_s     [2];
   logic [XLEN-1:0]        b_s     [2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         sel_s[i]   = req_sel[i*SEL_SIZE +: SEL_SIZE];
         shamt_s[i] = req_shift_amt[i*SHIFT_SIZE +: SHIFT_SIZE];
         a_s[i]     = req_a[i*XLEN +: XLEN];
         b_s[i]     = req_b[i*XLEN +: XLEN];
      end
   end

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: requester 0 wins whenever it is valid.
   always_comb begin
      grant_idx = 1'b0;
      if (req_valid == 2'b10) grant_idx = 1'b1;
   end
`else
   logic last_grant_q, last_grant_d;

   // Contention goes to the requester that did not win the last accepted
   // grant; a lone requester always wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      grant_idx = 1'b0;
      case (req_valid)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = ~last_grant_q;
         default: grant_idx = 1'b0;
      endcase
   end

   // Only an accepted grant moves the pointer; a withdrawn request leaves it.
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_any) last_grant_d = grant_idx;
   end

   // Reset value 1 makes requester 0 win the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_grant_q <= 1'b1;
      else     last_grant_q <= last_grant_d;
   end
`endif

   // A held result blocks acceptance unless the consumer takes it now. The rst
   // term keeps grants off during reset, since it acts without a clock edge.
   always_comb begin
      can_accept = (state_q == ST_IDLE) || rsp_ready;
      grant_any  = can_accept && (req_valid != 2'b00) && !rst;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_any) state_d = ST_HOLD;
         // A grant while the held result is consumed keeps HOLD with new data.
         ST_HOLD: if (rsp_ready && !grant_any) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      req_ready     = 2'b00;
      alu_enable    = 1'b0;
      alu_sel       = '0;
      alu_shift_amt = '0;
      alu_data_in_a = '0;
      alu_data_in_b = '0;
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
         alu_enable           = 1'b1;
         alu_sel              = sel_s[grant_idx];
         alu_shift_amt        = shamt_s[grant_idx];
         alu_data_in_a        = a_s[grant_idx];
         alu_data_in_b        = b_s[grant_idx];
      end
   end

   assign rsp_valid = (state_q == ST_HOLD);

   // ---------------------------------------------------------------------------
   // Response holding register
   // ---------------------------------------------------------------------------
   always_comb begin
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      if (grant_any) begin
         rsp_data_d = alu_data_out;
         rsp_id_d   = grant_idx;
      end
   end

   // NOTE: the response register is reset because its value is visible on
   // rsp_data immediately after reset; a pending result is simply dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data_q <= '0;
         rsp_id_q   <= 1'b0;
      end else begin
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign rsp_data = rsp_data_q;
   assign rsp_id   = rsp_id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SEL_SIZE, default 4, ALU operation-select width.
REQ-002 Parameter SHIFT_SIZE, default 5, ALU shift-amount width.
REQ-003 Parameter XLEN, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  2  bit i = requester i presents an operation.
REQ-007 req_ready  output  2  bit i = requester i's operation accepted this cycle.
REQ-008 req_sel  input  2*SEL_SIZE  select per requester; slice i = [i*SEL_SIZE +: SEL_SIZE].
REQ-009 req_shift_amt  input  2*SHIFT_SIZE  shift amount per requester, sliced likewise.
REQ-010 req_a  input  2*XLEN  operand A per requester, sliced likewise.
REQ-011 req_b  input  2*XLEN  operand B per requester, sliced likewise.
REQ-012 rsp_valid  output  1  registered result available.
REQ-013 rsp_ready  input  1  consumer takes the result.
REQ-014 rsp_data  output  XLEN  registered ALU result.
REQ-015 rsp_id  output  1  requester index owning rsp_data.
REQ-016 alu_enable  output  1  enable to the shared ALU.
REQ-017 alu_sel  output  SEL_SIZE  select to the ALU.
REQ-018 alu_shift_amt  output  SHIFT_SIZE  shift amount to the ALU.
REQ-019 alu_data_in_a / alu_data_in_b  output  XLEN each  operands to the ALU.
REQ-020 alu_data_out  input  XLEN  combinational ALU result.

Function
REQ-021 States: IDLE (rsp_valid=0), HOLD (rsp_valid=1).
REQ-022 Accept window (can_accept) = IDLE, or HOLD with rsp_ready=1.
REQ-023 During can_accept with at least one req_valid bit set, exactly one grant g; req_ready = one-hot(g), combinational, same cycle; otherwise req_ready=0.
REQ-024 Round-robin: one requester valid -> it wins; both valid -> the requester not granted last wins; last_grant updates only on an accepted grant.
REQ-025 Granted cycle: alu_enable=1; alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b = slice g. No grant: alu_enable=0, all other ALU outputs 0.
REQ-026 On a granted edge: rsp_data<=alu_data_out, rsp_id<=g, state<=HOLD. Latency is 1 cycle from acceptance to rsp_valid.
REQ-027 HOLD with rsp_ready=1 and no grant -> IDLE. HOLD with rsp_ready=1 and a grant -> stays HOLD with the new result. Throughput is 1 op/cycle.
REQ-028 HOLD with rsp_ready=0: rsp_data and rsp_id stable, req_ready=0, alu_enable=0.
REQ-029 rsp_ready while IDLE is ignored.
REQ-030 req_valid withdrawn before acceptance: no side effects; last_grant unchanged.

Reset
REQ-031 rst=1 forces immediately: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (requester 0 wins first contention); req_ready=0 and alu_enable=0 while rst=1.
REQ-032 Reset in HOLD discards the pending result; there is no replay.

Configuration
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins when both valid, and last_grant is not implemented.
REQ-034 Macro undefined: round-robin per REQ-024.

Verification
REQ-035 ALU stub alu_data_out=a+b. Req0 a=5, b=7, rsp_ready=1 -> req_ready=01 same cycle; next cycle rsp_valid=1, rsp_data=12, rsp_id=0.
REQ-036 Both valid for 4 cycles, rsp_ready=1, round-robin build -> grant order 0,1,0,1; FIXED_PRIO build -> 0,0,0,0.
REQ-037 Result held with rsp_ready=0 for 3 cycles and req1 valid -> rsp_data stable, req_ready=00, alu_enable=0; rsp_ready=1 -> req1 accepted that same cycle.
REQ-038 Back-to-back req0 ops 1+1, 2+2, 3+3 with rsp_ready=1 -> rsp_data 2, 4, 6 on consecutive cycles, rsp_valid continuously 1.
REQ-039 rst asserted in HOLD mid-cycle -> rsp_valid=0 without a clock edge; after release, first contention is won by requester 0.
REQ-040 No req_valid -> alu_enable=0, ALU operand outputs 0, state IDLE.
